mvm_ctrl: RTL and testbench
===========================

# mvm_ctrl

Sequencing controller for one matrix-vector multiply pass. It sits between the matrix and vector read memories and the `accum` datapath. It walks the matrix row-major, issues one matrix/vector element-pair read per cycle, and drives `ivalid`/`first`/`last` to the datapath aligned with the memory read data. It then counts `ovalid` results, writes each one to the output memory at its row index, and signals completion.

## Interface
- `MAX_ROWS`, default 64: largest supported row count.
- `MAX_COLS`, default 64: largest supported column count (vector length).
- `ACCUMW`, default 32: datapath result width.
- `ROWW`, default `$clog2(MAX_ROWS+1)`: row-count / row-address width.
- `COLW`, default `$clog2(MAX_COLS+1)`: column-count / vector-address width.
- `MADDRW`, default `$clog2(MAX_ROWS*MAX_COLS)`: matrix address width.

Ports:
- `clk`  in  1  single clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset; asserted while `rst`=0.
- `start`  in  1  one-cycle request; accepted only in IDLE.
- `cfg_rows`  in  ROWW  row count, latched on accepted `start`.
- `cfg_cols`  in  COLW  column count, latched on accepted `start`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse when the pass completes.
- `mem_ren`  out  1  read enable to both memories.
- `mat_raddr`  out  MADDRW  matrix read address (`row*cols+col`).
- `vec_raddr`  out  COLW  vector read address (`col`).
- `dp_ivalid`, `dp_first`, `dp_last`  out  1 each  datapath controls.
- `dp_ovalid`  in  1  datapath result valid.
- `dp_result`  in  ACCUMW  datapath result.
- `out_wen`  out  1  output memory write enable.
- `out_waddr`  out  ROWW  output row address.
- `out_wdata`  out  ACCUMW  output write data.

## Operation
- States:
  - IDLE: `start`=1 latches the config. If rows=0 or cols=0, go to DONE; otherwise go to ISSUE.
  - ISSUE: issue one read per cycle. After the last element (row=rows-1, col=cols-1), go to DRAIN.
  - DRAIN: wait until the result count reaches rows, then go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE.
- Counters:
  - col increments each ISSUE cycle and wraps to 0 after cols-1; row increments on each col wrap.
  - `mat_raddr` is a running linear counter, not a multiplier, and resets to 0 on accepted `start`.
- Control pipeline: `dp_ivalid`/`dp_first`/`dp_last` are the issue-stage values registered one cycle, to match the 1-cycle registered memory read latency.
  - `dp_first` = issued col==0.
  - `dp_last` = issued col==cols-1.
  - With cols=1, both are set on the same beat.
- Results:
  - `out_wen` = `dp_ovalid` while in ISSUE or DRAIN. `out_wdata` = `dp_result` and `out_waddr` = result count, all combinational from these inputs.
  - The result count increments on each accepted `dp_ovalid`.
  - Results may arrive while still in ISSUE; completion is latency-agnostic because it relies on counting results.
- `dp_ovalid` in IDLE or DONE is ignored: no write, no count.
- `start` while `busy` is ignored; the configuration is not re-latched.
- Reset mid-pass:
  - Abandons the pass and returns to IDLE.
  - The pipeline and counters are cleared.
  - No `done` is produced for the abandoned pass.

## Timing
- Reset values: `busy`, `done`, `mem_ren`, `dp_ivalid`, `dp_first`, `dp_last`, `out_wen` = 0; all addresses = 0.
- Accepted `start` in cycle T: ISSUE from T+1.
  - First `mem_ren`=1 with address 0/0 at T+1; `dp_ivalid` first at T+2.
  - The last read is at T+rows·cols; the last `dp_ivalid` is at T+rows·cols+1.
- rows or cols = 0: `busy`=1 and `done`=1 at T+1, no reads, IDLE at T+2.
- `done` is asserted in the cycle after the rows-th `dp_ovalid`; `busy` drops the following cycle.
- A new `start` can be accepted in the cycle `busy`=0, i.e. back-to-back passes have one IDLE cycle.

## Structure
- Package `mvm_pkg`: state enum (IDLE, ISSUE, DRAIN, DONE) and the shared default widths `ACCUMW`, `MAX_ROWS`, `MAX_COLS`.
- Sub-module `mvm_addr_gen`:
  - row/col/linear counters with load, advance and last-element flag;
  - registered issue-to-datapath control stage.
- The FSM and result counter stay in `mvm_ctrl`.

## Test plan
- rows=2, cols=3, accum latency 1:
  - `mat_raddr` 0,1,2,3,4,5; `vec_raddr` 0,1,2,0,1,2 at T+1..T+6;
  - `dp_first` at T+2 and T+5; `dp_last` at T+4 and T+7;
  - writes to rows 0 and 1 carry the model sums; a single `done`.
- rows=1, cols=1: one read; `dp_ivalid`/`dp_first`/`dp_last` all high at T+2; one write to addr 0; `done` after it.
- cfg_rows=0, cols=5: `done` at T+1, `mem_ren` never asserted, no writes.
- `start` pulsed in ISSUE with different cfg: address sequence unchanged, exactly one `done`, result count equals the original rows.
- Variable result latency (1, then 5 cycles) with rows=4, cols=2: `done` exactly one cycle after the 4th `dp_ovalid`; a spurious `dp_ovalid` in IDLE gives no write.
- Reset asserted mid-ISSUE:
  - all outputs go to 0 at once, asynchronously;
  - no `done`;
  - a following start with rows=2, cols=2 runs from address 0 and produces correct results.

Source files
------------

// File: rtl/mvm_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mvm_pkg : shared state encoding and default widths for mvm_ctrl  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package mvm_pkg;

  localparam int MAX_ROWS = 64;
  localparam int MAX_COLS = 64;
  localparam int ACCUMW   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mvm_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mvm_if : config, memory, datapath and output-write bundle        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mvm_if #(
  parameter int ACCUMW = mvm_pkg::ACCUMW,
  parameter int ROWW   = $clog2(mvm_pkg::MAX_ROWS + 1),
  parameter int COLW   = $clog2(mvm_pkg::MAX_COLS + 1),
  parameter int MADDRW = $clog2(mvm_pkg::MAX_ROWS * mvm_pkg::MAX_COLS)
);
  logic              start;
  logic [ROWW-1:0]   cfg_rows;
  logic [COLW-1:0]   cfg_cols;
  logic              busy;
  logic              done;
  logic              mem_ren;
  logic [MADDRW-1:0] mat_raddr;
  logic [COLW-1:0]   vec_raddr;
  logic              dp_ivalid;
  logic              dp_first;
  logic              dp_last;
  logic              dp_ovalid;
  logic [ACCUMW-1:0] dp_result;
  logic              out_wen;
  logic [ROWW-1:0]   out_waddr;
  logic [ACCUMW-1:0] out_wdata;

  modport master (
    output start, cfg_rows, cfg_cols, dp_ovalid, dp_result,
    input  busy, done, mem_ren, mat_raddr, vec_raddr,
           dp_ivalid, dp_first, dp_last, out_wen, out_waddr, out_wdata
  );

  modport slave (
    input  start, cfg_rows, cfg_cols, dp_ovalid, dp_result,
    output busy, done, mem_ren, mat_raddr, vec_raddr,
           dp_ivalid, dp_first, dp_last, out_wen, out_waddr, out_wdata
  );
endinterface
`default_nettype wire

// File: rtl/mvm_addr_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mvm_addr_gen : row/col/linear read counters and issue pipeline   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mvm_addr_gen #(
  parameter int ROWW   = 7,
  parameter int COLW   = 7,
  parameter int MADDRW = 12
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_load,
  input  wire logic              i_adv,
  input  wire logic [ROWW-1:0]   i_rows,
  input  wire logic [COLW-1:0]   i_cols,
  output logic      [MADDRW-1:0] o_maddr,
  output logic      [COLW-1:0]   o_col,
  output logic                   o_last_elem,
  output logic                   o_ivalid,
  output logic                   o_first,
  output logic                   o_last
);

  logic [ROWW-1:0]   r_row;
  logic [COLW-1:0]   r_col;
  logic [MADDRW-1:0] r_maddr;
  logic              r_ivalid;
  logic              r_first;
  logic              r_last;
  logic              w_col_last;
  logic              w_row_last;

  assign w_col_last = (r_col == i_cols - COLW'(1));
  assign w_row_last = (r_row == i_rows - ROWW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row    <= '0;
      r_col    <= '0;
      r_maddr  <= '0;
      r_ivalid <= 1'b0;
      r_first  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      if (i_load) begin
        r_row   <= '0;
        r_col   <= '0;
        r_maddr <= '0;
      end else if (i_adv) begin
        // linear address runs alongside row/col so no multiplier is needed
        r_maddr <= r_maddr + MADDRW'(1);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + ROWW'(1);
        end else begin
          r_col <= r_col + COLW'(1);
        end
      end
      // delayed one cycle to line up with the registered memory read data
      r_ivalid <= i_adv;
      r_first  <= i_adv && (r_col == '0);
      r_last   <= i_adv && w_col_last;
    end
  end

  assign o_maddr     = r_maddr;
  assign o_col       = r_col;
  assign o_last_elem = w_row_last && w_col_last;
  assign o_ivalid    = r_ivalid;
  assign o_first     = r_first;
  assign o_last      = r_last;

endmodule
`default_nettype wire

// File: rtl/mvm_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mvm_ctrl : matrix-vector pass sequencer with result write-back   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mvm_ctrl #(
  parameter int MAX_ROWS = mvm_pkg::MAX_ROWS,
  parameter int MAX_COLS = mvm_pkg::MAX_COLS,
  parameter int ACCUMW   = mvm_pkg::ACCUMW,
  parameter int ROWW     = $clog2(MAX_ROWS + 1),
  parameter int COLW     = $clog2(MAX_COLS + 1),
  parameter int MADDRW   = $clog2(MAX_ROWS * MAX_COLS)
) (
  input  wire logic clk,
  input  wire logic rst,
  mvm_if.slave      bus
);
  import mvm_pkg::*;

  state_t          r_state;
  logic [ROWW-1:0] r_rows;
  logic [COLW-1:0] r_cols;
  logic [ROWW-1:0] r_res_cnt;
  logic            w_accept;
  logic            w_adv;
  logic            w_res_ok;
  logic            w_last_elem;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_adv    = (r_state == S_ISSUE);
  assign w_res_ok = bus.dp_ovalid && ((r_state == S_ISSUE) || (r_state == S_DRAIN));

  mvm_addr_gen #(
    .ROWW   (ROWW),
    .COLW   (COLW),
    .MADDRW (MADDRW)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_adv       (w_adv),
    .i_rows      (r_rows),
    .i_cols      (r_cols),
    .o_maddr     (bus.mat_raddr),
    .o_col       (bus.vec_raddr),
    .o_last_elem (w_last_elem),
    .o_ivalid    (bus.dp_ivalid),
    .o_first     (bus.dp_first),
    .o_last      (bus.dp_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rows    <= '0;
      r_cols    <= '0;
      r_res_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_rows    <= bus.cfg_rows;
            r_cols    <= bus.cfg_cols;
            r_res_cnt <= '0;
            r_state   <= ((bus.cfg_rows == '0) || (bus.cfg_cols == '0)) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_last_elem) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          // completion keys off the result count, so datapath latency is free
          if ((w_res_ok && (r_res_cnt == r_rows - ROWW'(1))) || (r_res_cnt == r_rows))
            r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_res_ok) r_res_cnt <= r_res_cnt + ROWW'(1);
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.mem_ren   = (r_state == S_ISSUE);
  assign bus.out_wen   = w_res_ok;
  assign bus.out_waddr = r_res_cnt;
  assign bus.out_wdata = bus.dp_result;

endmodule
`default_nettype wire

// File: tb/tb_mvm_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mvm_ctrl : directed self-checking bench for mvm_ctrl          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_mvm_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spur = 1'b0;

  mvm_if bus ();

  mvm_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int lat_tab [16];
  int row_idx = 0;
  int acc = 0;
  int prod;
  logic prev_ren = 1'b0;
  int prev_m = 0;
  int prev_v = 0;
  int pend_data[$], pend_due[$];
  int ren_cyc[$], ren_m[$], ren_v[$];
  int iv_cyc[$], first_cyc[$], last_cyc[$];
  int wr_cyc[$], wr_addr[$], wr_data[$], done_cyc[$];

  // memory contents as functions of the address
  function automatic int m_val(input int a);
    return a * 3 + 1;
  endfunction

  function automatic int v_val(input int c);
    return c + 2;
  endfunction

  // datapath result driver: cycle counter plus delayed results
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    bus.dp_ovalid = 1'b0;
    bus.dp_result = '0;
    while (pend_due.size() > 0 && pend_due[0] < cyc) begin
      void'(pend_due.pop_front());
      void'(pend_data.pop_front());
    end
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      bus.dp_ovalid = 1'b1;
      bus.dp_result = pend_data[0];
      void'(pend_due.pop_front());
      void'(pend_data.pop_front());
    end else if (spur) begin
      bus.dp_ovalid = 1'b1;
      bus.dp_result = 32'hDEAD_BEEF;
    end
  end

  // memory + accumulator model and event log
  always @(negedge clk) begin
    if (!rst) begin
      pend_due.delete();
      pend_data.delete();
      prev_ren = 1'b0;
      row_idx  = 0;
    end else begin
      if (bus.mem_ren) begin
        ren_cyc.push_back(cyc);
        ren_m.push_back(int'(bus.mat_raddr));
        ren_v.push_back(int'(bus.vec_raddr));
      end
      if (bus.dp_ivalid) begin
        iv_cyc.push_back(cyc);
        prod = prev_ren ? m_val(prev_m) * v_val(prev_v) : 0;
        acc  = bus.dp_first ? prod : acc + prod;
        if (bus.dp_first) first_cyc.push_back(cyc);
        if (bus.dp_last) begin
          last_cyc.push_back(cyc);
          pend_data.push_back(acc);
          pend_due.push_back(cyc + lat_tab[row_idx % 16]);
          row_idx = row_idx + 1;
        end
      end
      if (bus.out_wen) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(bus.out_waddr));
        wr_data.push_back(int'(bus.out_wdata));
      end
      if (bus.done) done_cyc.push_back(cyc);
      prev_ren = bus.mem_ren;
      prev_m   = int'(bus.mat_raddr);
      prev_v   = int'(bus.vec_raddr);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    ren_cyc.delete(); ren_m.delete(); ren_v.delete();
    iv_cyc.delete(); first_cyc.delete(); last_cyc.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); done_cyc.delete();
    row_idx = 0;
    for (int i = 0; i < 16; i++) lat_tab[i] = 1;
  endtask

  task automatic start_pass(input int rows, input int cols, output int t);
    bus.cfg_rows = 7'(rows);
    bus.cfg_cols = 7'(cols);
    bus.start    = 1'b1;
    t = cyc;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (done_cyc.size() == 0) begin
      failures++;
      $display("FAIL wait_done timeout: got no done within %0d cycles, required one", budget);
    end
    step();
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.cfg_rows = '0; bus.cfg_cols = '0;
    clear_logs();
    repeat (3) step();
    checks++;
    if ({bus.busy, bus.done, bus.mem_ren, bus.dp_ivalid, bus.dp_first, bus.dp_last, bus.out_wen} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0000000",
               {bus.busy, bus.done, bus.mem_ren, bus.dp_ivalid, bus.dp_first, bus.dp_last, bus.out_wen});
    end
    checks++;
    if ({bus.mat_raddr, bus.vec_raddr, bus.out_waddr} !== '0) begin
      failures++;
      $display("FAIL reset_addr got mat=%0d vec=%0d out=%0d exp=0", bus.mat_raddr, bus.vec_raddr, bus.out_waddr);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_2x3();
    int t;
    int ev[6];
    ev = '{0, 1, 2, 0, 1, 2};
    clear_logs();
    start_pass(2, 3, t);
    wait_done(100);
    checks++;
    if (ren_cyc.size() != 6) begin
      failures++; $display("FAIL 2x3_reads got=%0d exp=6", ren_cyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (ren_m[i] != i || ren_v[i] != ev[i] || ren_cyc[i] != t + 1 + i) begin
          failures++;
          $display("FAIL 2x3_addr[%0d] got m=%0d v=%0d c=%0d exp m=%0d v=%0d c=%0d",
                   i, ren_m[i], ren_v[i], ren_cyc[i], i, ev[i], t + 1 + i);
        end
      end
    end
    checks++;
    if (first_cyc.size() != 2 || last_cyc.size() != 2) begin
      failures++; $display("FAIL 2x3_first_last_count got f=%0d l=%0d exp 2/2", first_cyc.size(), last_cyc.size());
    end else if (first_cyc[0] != t + 2 || first_cyc[1] != t + 5 || last_cyc[0] != t + 4 || last_cyc[1] != t + 7) begin
      failures++;
      $display("FAIL 2x3_first_last got f=%0d,%0d l=%0d,%0d exp f=%0d,%0d l=%0d,%0d",
               first_cyc[0] - t, first_cyc[1] - t, last_cyc[0] - t, last_cyc[1] - t, 2, 5, 4, 7);
    end
    checks++;
    if (wr_cyc.size() != 2) begin
      failures++; $display("FAIL 2x3_writes got=%0d exp=2", wr_cyc.size());
    end else if (wr_addr[0] != 0 || wr_data[0] != 42 || wr_addr[1] != 1 || wr_data[1] != 123) begin
      failures++;
      $display("FAIL 2x3_wdata got %0d:%0d %0d:%0d exp 0:42 1:123", wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 9) begin
      failures++; $display("FAIL 2x3_done got count=%0d exp one pulse at T+9", done_cyc.size());
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL 2x3_idle got busy=%b exp 0", bus.busy);
    end
  endtask

  task automatic test_1x1();
    int t;
    clear_logs();
    start_pass(1, 1, t);
    wait_done(50);
    checks++;
    if (ren_cyc.size() != 1 || ren_m[0] != 0 || ren_v[0] != 0 || ren_cyc[0] != t + 1) begin
      failures++; $display("FAIL 1x1_read got count=%0d exp one read of 0/0 at T+1", ren_cyc.size());
    end
    checks++;
    if (iv_cyc.size() != 1 || first_cyc.size() != 1 || last_cyc.size() != 1 ||
        iv_cyc[0] != t + 2 || first_cyc[0] != t + 2 || last_cyc[0] != t + 2) begin
      failures++;
      $display("FAIL 1x1_ctrl got iv=%0d f=%0d l=%0d exp one each at T+2", iv_cyc.size(), first_cyc.size(), last_cyc.size());
    end
    checks++;
    if (wr_cyc.size() != 1 || wr_addr[0] != 0 || wr_data[0] != 2 || wr_cyc[0] != t + 3) begin
      failures++; $display("FAIL 1x1_write got count=%0d exp one write 0:2 at T+3", wr_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 4) begin
      failures++; $display("FAIL 1x1_done got count=%0d exp one pulse at T+4", done_cyc.size());
    end
  endtask

  task automatic test_zero();
    int t;
    clear_logs();
    start_pass(0, 5, t);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b1) begin
      failures++; $display("FAIL zero_t1 got busy=%b done=%b exp 1/1", bus.busy, bus.done);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL zero_t2 got busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
    start_pass(3, 0, t);
    repeat (3) step();
    checks++;
    if (ren_cyc.size() != 0 || wr_cyc.size() != 0 || done_cyc.size() != 2 || done_cyc[1] != t + 1) begin
      failures++;
      $display("FAIL zero_activity got reads=%0d writes=%0d dones=%0d exp 0/0/2", ren_cyc.size(), wr_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_restart_ignored();
    int t;
    clear_logs();
    start_pass(2, 2, t);
    step();
    bus.cfg_rows = 7'd3; bus.cfg_cols = 7'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(100);
    checks++;
    if (ren_cyc.size() != 4 || ren_m[3] != 3 || ren_v[3] != 1) begin
      failures++; $display("FAIL restart_reads got count=%0d exp 4 ending at 3/1", ren_cyc.size());
    end
    checks++;
    if (wr_cyc.size() != 2 || wr_data[0] != 14 || wr_data[1] != 44 || wr_addr[1] != 1) begin
      failures++; $display("FAIL restart_writes got count=%0d exp 2 writes 14,44", wr_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 7) begin
      failures++; $display("FAIL restart_done got count=%0d exp one pulse at T+7", done_cyc.size());
    end
  endtask

  task automatic test_latency();
    int t;
    int ed[4];
    int ec[4];
    ed = '{14, 44, 74, 104};
    clear_logs();
    lat_tab[2] = 5;
    lat_tab[3] = 5;
    start_pass(4, 2, t);
    ec = '{t + 4, t + 6, t + 12, t + 14};
    wait_done(200);
    checks++;
    if (wr_cyc.size() != 4) begin
      failures++; $display("FAIL lat_writes got=%0d exp=4", wr_cyc.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_addr[i] != i || wr_data[i] != ed[i] || wr_cyc[i] != ec[i]) begin
          failures++;
          $display("FAIL lat_write[%0d] got a=%0d d=%0d c=%0d exp a=%0d d=%0d c=%0d",
                   i, wr_addr[i], wr_data[i], wr_cyc[i] - t, i, ed[i], ec[i] - t);
        end
      end
      checks++;
      if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[3] + 1 || done_cyc[0] != t + 15) begin
        failures++; $display("FAIL lat_done got count=%0d exp one pulse at T+15", done_cyc.size());
      end
    end
    spur = 1'b1;
    step();
    checks++;
    if (bus.out_wen !== 1'b0) begin
      failures++; $display("FAIL idle_ovalid got out_wen=%b exp 0", bus.out_wen);
    end
    spur = 1'b0;
    repeat (2) step();
    checks++;
    if (wr_cyc.size() != 4 || done_cyc.size() != 1) begin
      failures++; $display("FAIL idle_ovalid_log got writes=%0d dones=%0d exp 4/1", wr_cyc.size(), done_cyc.size());
    end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_logs();
    start_pass(3, 3, t);
    repeat (3) step();
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.mem_ren, bus.dp_ivalid, bus.dp_first, bus.dp_last, bus.out_wen} !== 7'b0) begin
      failures++;
      $display("FAIL rstmid_ctrl got=%b exp=0000000",
               {bus.busy, bus.done, bus.mem_ren, bus.dp_ivalid, bus.dp_first, bus.dp_last, bus.out_wen});
    end
    checks++;
    if ({bus.mat_raddr, bus.vec_raddr, bus.out_waddr} !== '0) begin
      failures++; $display("FAIL rstmid_addr got mat=%0d vec=%0d out=%0d exp=0", bus.mat_raddr, bus.vec_raddr, bus.out_waddr);
    end
    repeat (2) step();
    rst = 1'b1;
    repeat (6) step();
    checks++;
    if (done_cyc.size() != 0) begin
      failures++; $display("FAIL rstmid_nodone got dones=%0d exp=0", done_cyc.size());
    end
    clear_logs();
    start_pass(2, 2, t);
    wait_done(100);
    checks++;
    if (ren_cyc.size() != 4 || ren_m[0] != 0 || ren_v[0] != 0 || ren_m[3] != 3 || ren_cyc[0] != t + 1) begin
      failures++; $display("FAIL rstmid_reads got count=%0d exp 4 from address 0", ren_cyc.size());
    end
    checks++;
    if (wr_cyc.size() != 2 || wr_addr[0] != 0 || wr_data[0] != 14 || wr_addr[1] != 1 || wr_data[1] != 44) begin
      failures++; $display("FAIL rstmid_writes got count=%0d exp 0:14 1:44", wr_cyc.size());
    end
    checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != t + 7) begin
      failures++; $display("FAIL rstmid_done got count=%0d exp one pulse at T+7", done_cyc.size());
    end
  endtask

  initial begin
    test_reset();
    test_2x3();
    test_1x1();
    test_zero();
    test_restart_ignored();
    test_latency();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
